// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
//   Request/result bundle for the bit-serial adder.
//   master: drives start, a, b, cin; observes busy, done, sum, cout.
//   slave : the adder itself.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
//   Operands are captured on a start accepted in IDLE. busy is high for WIDTH
//   cycles (RUN), followed by a one-cycle done pulse (DONE). sum/cout are
//   registered and change only on the RUN->DONE edge or on reset.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : serial_adder_ctrl_if.slave (start, a, b, cin -> busy, done, sum, cout)
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] shs;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] shs_nxt;

    // 1-bit full-adder cell on the operand LSBs, plus the partial-sum shift
    // with the new bit entering at the MSB. After WIDTH shifts the first bit
    // computed has reached bit 0.
    always_comb begin
        fa_s             = sha[0] ^ shb[0] ^ carry;
        fa_co            = (sha[0] & shb[0]) | (sha[0] & carry) | (shb[0] & carry);
        shs_nxt          = shs >> 1;
        shs_nxt[WIDTH-1] = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sha    <= '0;
            shb    <= '0;
            shs    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sha    <= bus.a;
                        shb    <= bus.b;
                        carry  <= bus.cin;
                        shs    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    carry <= fa_co;
                    sha   <= sha >> 1;
                    shb   <= shb >> 1;
                    shs   <= shs_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum_q  <= shs_nxt;
                        cout_q <= fa_co;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Directed/table-driven bench for serial_adder_ctrl at WIDTH=8, 1 and 32,
//   plus corner sequences (held start, mid-RUN reset) and a random regression.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8))  i8  ();
    serial_adder_ctrl_if #(.WIDTH(1))  i1  ();
    serial_adder_ctrl_if #(.WIDTH(32)) i32 ();

    serial_adder_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
    serial_adder_ctrl #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(i1));
    serial_adder_ctrl #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(i32));

    int checks   = 0;
    int failures = 0;

    logic [8:0]  prev8  = '0;
    logic [1:0]  prev1  = '0;
    logic [32:0] prev32 = '0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic s;
        logic co;
    } vec1_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // done must be a single-cycle pulse that never overlaps busy
    logic d8p = 1'b0, d1p = 1'b0, d32p = 1'b0;
    always @(negedge clk) begin
        if (i8.done) begin
            checks++;
            if (i8.busy || d8p) begin failures++; $display("FAIL done_pulse_w8 busy=%0b prev_done=%0b", i8.busy, d8p); end
        end
        if (i1.done) begin
            checks++;
            if (i1.busy || d1p) begin failures++; $display("FAIL done_pulse_w1 busy=%0b prev_done=%0b", i1.busy, d1p); end
        end
        if (i32.done) begin
            checks++;
            if (i32.busy || d32p) begin failures++; $display("FAIL done_pulse_w32 busy=%0b prev_done=%0b", i32.busy, d32p); end
        end
        d8p  = i8.done;
        d1p  = i1.done;
        d32p = i32.done;
    end

    // Each op task starts just after an edge with the DUT in IDLE and ends
    // one cycle after the done pulse (DUT back in IDLE).
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [8:0] exp, input string nm);
        i8.a = a; i8.b = b; i8.cin = ci; i8.start = 1'b1;
        tick();
        i8.start = 1'b0;
        i8.a = ~a; i8.b = ~b; i8.cin = ~ci;
        for (int k = 0; k < 8; k++) begin
            chk({nm, "_busy"}, 64'(i8.busy), 64'd1);
            chk({nm, "_nodone"}, 64'(i8.done), 64'd0);
            chk({nm, "_hold"}, 64'({i8.cout, i8.sum}), 64'(prev8));
            tick();
        end
        chk({nm, "_done"}, 64'(i8.done), 64'd1);
        chk({nm, "_idlebusy"}, 64'(i8.busy), 64'd0);
        chk({nm, "_result"}, 64'({i8.cout, i8.sum}), 64'(exp));
        prev8 = exp;
        tick();
        chk({nm, "_doneclr"}, 64'(i8.done), 64'd0);
    endtask

    task automatic op1(input logic a, input logic b, input logic ci,
                       input logic [1:0] exp, input string nm);
        i1.a = a; i1.b = b; i1.cin = ci; i1.start = 1'b1;
        tick();
        i1.start = 1'b0;
        i1.a = ~a; i1.b = ~b; i1.cin = ~ci;
        chk({nm, "_busy"}, 64'(i1.busy), 64'd1);
        chk({nm, "_hold"}, 64'({i1.cout, i1.sum}), 64'(prev1));
        tick();
        chk({nm, "_done"}, 64'(i1.done), 64'd1);
        chk({nm, "_result"}, 64'({i1.cout, i1.sum}), 64'(exp));
        prev1 = exp;
        tick();
        chk({nm, "_doneclr"}, 64'(i1.done), 64'd0);
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic [32:0] exp, input string nm);
        i32.a = a; i32.b = b; i32.cin = ci; i32.start = 1'b1;
        tick();
        i32.start = 1'b0;
        i32.a = ~a; i32.b = ~b;
        for (int k = 0; k < 32; k++) begin
            chk({nm, "_busy"}, 64'(i32.busy), 64'd1);
            chk({nm, "_hold"}, 64'({i32.cout, i32.sum}), 64'(prev32));
            tick();
        end
        chk({nm, "_done"}, 64'(i32.done), 64'd1);
        chk({nm, "_result"}, 64'({i32.cout, i32.sum}), 64'(exp));
        prev32 = exp;
        tick();
        chk({nm, "_doneclr"}, 64'(i32.done), 64'd0);
    endtask

    initial begin
        vec8_t v8[8];
        vec1_t v1[8];
        logic [7:0]  ra, rb;
        logic [31:0] wa, wb;
        logic        rc;

        v8[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        v8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        v8[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        v8[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        v8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        v8[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        v8[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        v8[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        v1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        v1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        v1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        v1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        v1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        i8.start  = 1'b0; i8.a  = '0; i8.b  = '0; i8.cin  = 1'b0;
        i1.start  = 1'b0; i1.a  = '0; i1.b  = '0; i1.cin  = 1'b0;
        i32.start = 1'b0; i32.a = '0; i32.b = '0; i32.cin = 1'b0;

        // Reset, with start asserted to show reset wins
        rst = 1'b1;
        i8.start = 1'b1;
        tick();
        tick();
        i8.start = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_busy8", 64'(i8.busy), 64'd0);
        chk("rst_done8", 64'(i8.done), 64'd0);
        chk("rst_res8",  64'({i8.cout, i8.sum}), 64'd0);
        chk("rst_busy1", 64'(i1.busy), 64'd0);
        chk("rst_res1",  64'({i1.cout, i1.sum}), 64'd0);
        chk("rst_res32", 64'({i32.cout, i32.sum}), 64'd0);

        // Directed vectors, WIDTH=8 and WIDTH=1
        for (int i = 0; i < 8; i++)
            op8(v8[i].a, v8[i].b, v8[i].cin, {v8[i].co, v8[i].s}, $sformatf("v8_%0d", i));
        for (int i = 0; i < 8; i++)
            op1(v1[i].a, v1[i].b, v1[i].cin, {v1[i].co, v1[i].s}, $sformatf("v1_%0d", i));
        op32(32'hFFFF_FFFF, 32'h0, 1'b1, {1'b1, 32'h0}, "w32_wrap");
        op32(32'h1234_5678, 32'h8765_4321, 1'b0, {1'b0, 32'h9999_9999}, "w32_mix");

        // start held high: one op per 10 cycles, operands changed mid-RUN.
        // Captures at E0, E0+10, E0+20; done after edges E0+8, +18, +28.
        i8.a = 8'h11; i8.b = 8'h22; i8.cin = 1'b0; i8.start = 1'b1;
        tick();
        for (int n = 0; n < 31; n++) begin
            if (n == 3)  begin i8.a = 8'h55; i8.b = 8'h66; end
            if (n == 13) begin i8.a = 8'h70; i8.b = 8'h90; i8.cin = 1'b1; end
            chk($sformatf("hold_done_n%0d", n), 64'(i8.done), 64'((n % 10) == 8));
            chk($sformatf("hold_busy_n%0d", n), 64'(i8.busy), 64'(n < 28 && (n % 10) < 8));
            if (n == 8)  chk("hold_res0", 64'({i8.cout, i8.sum}), 64'h033);
            if (n == 18) chk("hold_res1", 64'({i8.cout, i8.sum}), 64'h0BB);
            if (n == 28) begin
                chk("hold_res2", 64'({i8.cout, i8.sum}), 64'h101);
                i8.start = 1'b0;
            end
            tick();
        end
        prev8 = 9'h101;

        // Single start pulse during RUN is neither taken nor queued
        i8.a = 8'h01; i8.b = 8'h02; i8.cin = 1'b0; i8.start = 1'b1;
        tick();
        i8.start = 1'b0;
        tick(); tick();
        i8.a = 8'hF0; i8.b = 8'h0F; i8.start = 1'b1;
        tick();
        i8.start = 1'b0;
        for (int n = 3; n < 14; n++) begin
            if (n == 8) chk("pulse_res", 64'({i8.cout, i8.sum}), 64'h003);
            chk($sformatf("pulse_busy_n%0d", n), 64'(i8.busy), 64'(n < 8));
            tick();
        end
        prev8 = 9'h003;

        // Reset at RUN bit 4 of 0x7F+0x01: aborted, no done pulse
        i8.a = 8'h7F; i8.b = 8'h01; i8.cin = 1'b0; i8.start = 1'b1;
        tick();
        i8.start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(i8.busy), 64'd0);
        chk("abort_done", 64'(i8.done), 64'd0);
        chk("abort_res",  64'({i8.cout, i8.sum}), 64'd0);
        for (int n = 0; n < 10; n++) begin
            tick();
            chk($sformatf("abort_nodone_%0d", n), 64'(i8.done | i8.busy), 64'd0);
        end
        prev8 = '0; prev1 = '0; prev32 = '0;
        op8(8'h12, 8'h34, 1'b0, 9'h046, "after_abort");

        // Random regression against the unsigned sum
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            op8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc), "rnd8");
        end
        for (int i = 0; i < 1000; i++) begin
            wa = $urandom; wb = $urandom; rc = 1'($urandom);
            op32(wa, wb, rc, {1'b0, wa} + {1'b0, wb} + 33'(rc), "rnd32");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
